// File: rtl/dlsc_data_unpacker.sv
// dlsc_data_unpacker: splits a stream of packed 32-bit beats into 1..4-byte words, right-aligned.
// Optional macro DLSC_DATA_UNPACKER_ZERO_EN forces out_data bytes above bpw to zero.
`default_nettype none

module dlsc_data_unpacker #(
  parameter int WLEN       = 12,
  parameter bit WORDS_ZERO = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            cmd_done,
  output logic            cmd_ready,
  input  logic            cmd_valid,
  input  logic [1:0]      cmd_offset,
  input  logic [1:0]      cmd_bpw,
  input  logic [WLEN-1:0] cmd_words,
  output logic            in_ready,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            out_last,
  output logic [31:0]     out_data
);

  logic            active;
  logic [1:0]      off_r;
  logic [1:0]      bpw_r;
  logic [WLEN-1:0] words_left;   // words still to load, minus one
  logic [WLEN+1:0] beats_left;
  logic            first_beat;
  logic [2:0]      last_bytes;
  logic [2:0]      count;
  logic [55:0]     buffer;

  // command decode
  logic [WLEN:0]   n_words;
  logic [2:0]      cmd_bpw_p1;
  logic [WLEN+3:0] nw_ext;
  logic [WLEN+3:0] bw_ext;
  logic [WLEN+3:0] total_p3;
  logic [WLEN+1:0] beats_init;
  logic [2:0]      last_bytes_init;
  logic [WLEN-1:0] words_init;

  assign n_words    = WORDS_ZERO ? ({1'b0, cmd_words} + 1'b1) : {1'b0, cmd_words};
  assign cmd_bpw_p1 = {1'b0, cmd_bpw} + 3'd1;
  assign nw_ext     = {3'b000, n_words};
  assign bw_ext     = {{(WLEN+1){1'b0}}, cmd_bpw_p1};
  assign total_p3   = nw_ext * bw_ext + {{(WLEN+2){1'b0}}, cmd_offset} + 3'd3;
  assign beats_init = total_p3[WLEN+3:2];
  // (total-1) mod 4, plus one: bytes used from the final beat
  assign last_bytes_init = {1'b0, total_p3[1:0]} + 3'd1;
  assign words_init = WORDS_ZERO ? cmd_words : (cmd_words - 1'b1);

  // datapath control
  logic [2:0]  need;
  logic        load;
  logic        cmd_fire;
  logic        in_fire;
  logic        out_fire;
  logic [2:0]  cnt_rem;
  logic [1:0]  skip;
  logic [2:0]  n_app;
  logic [31:0] din_sh;
  logic [55:0] shifted;
  logic [55:0] buf_nxt;
  logic [2:0]  count_nxt;
  logic [31:0] out_word;

  assign cmd_ready = !active;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign out_fire  = out_valid && out_ready;
  assign need      = {1'b0, bpw_r} + 3'd1;
  assign load      = (out_ready || !out_valid) && active && (count >= need);
  assign cnt_rem   = load ? (count - need) : count;
  assign in_ready  = active && (beats_left != '0) && (cnt_rem <= 3'd3);
  assign in_fire   = in_valid && in_ready;
  assign skip      = first_beat ? off_r : 2'd0;
  assign n_app     = ((beats_left == {{(WLEN+1){1'b0}}, 1'b1}) ? last_bytes : 3'd4) - {1'b0, skip};
  assign din_sh    = in_data >> {skip, 3'b000};
  assign shifted   = load ? (buffer >> {need, 3'b000}) : buffer;
  assign count_nxt = cnt_rem + (in_fire ? n_app : 3'd0);

  always_comb begin
    buf_nxt = shifted;
    for (int i = 0; i < 7; i++) begin
      logic [2:0] idx;
      logic [2:0] rel;
      idx = i[2:0];
      rel = idx - cnt_rem;
      if (in_fire && (idx >= cnt_rem) && ({1'b0, idx} < ({1'b0, cnt_rem} + {1'b0, n_app})))
        buf_nxt[8*i +: 8] = din_sh[{rel[1:0], 3'b000} +: 8];
    end
  end

`ifdef DLSC_DATA_UNPACKER_ZERO_EN
  always_comb begin
    out_word = buffer[31:0];
    for (int b = 1; b < 4; b++) begin
      if (b > int'(bpw_r))
        out_word[8*b +: 8] = 8'h00;
    end
  end
`else
  assign out_word = buffer[31:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= 1'b0;
      count      <= 3'd0;
      beats_left <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      cmd_done   <= 1'b0;
    end else begin
      cmd_done <= out_fire && out_last;
      if (cmd_fire) begin
        active     <= 1'b1;
        count      <= 3'd0;
        beats_left <= beats_init;
      end else begin
        if (out_fire && out_last)
          active <= 1'b0;
        count <= count_nxt;
        if (in_fire)
          beats_left <= beats_left - 1'b1;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_last  <= (words_left == '0);
      end else if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // configuration and data registers carry no reset
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      off_r      <= cmd_offset;
      bpw_r      <= cmd_bpw;
      words_left <= words_init;
      last_bytes <= last_bytes_init;
      first_beat <= 1'b1;
    end else begin
      if (in_fire)
        first_beat <= 1'b0;
      if (load)
        words_left <= words_left - 1'b1;
    end
    buffer <= buf_nxt;
    if (load)
      out_data <= out_word;
  end

endmodule

`default_nettype wire

// File: tb/tb_dlsc_data_unpacker.sv
// Self-checking bench for dlsc_data_unpacker: directed table, reset abort, random commands vs byte-stream model.
`default_nettype none

module tb_dlsc_data_unpacker;
  localparam int WLEN = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_done, cmd_ready, cmd_valid;
  logic [1:0]      cmd_offset, cmd_bpw;
  logic [WLEN-1:0] cmd_words;
  logic            in_ready, in_valid;
  logic [31:0]     in_data;
  logic            out_ready, out_valid, out_last;
  logic [31:0]     out_data;

  dlsc_data_unpacker #(.WLEN(WLEN), .WORDS_ZERO(1'b0)) dut (
    .clk(clk), .rst(rst), .cmd_done(cmd_done), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
    .cmd_offset(cmd_offset), .cmd_bpw(cmd_bpw), .cmd_words(cmd_words),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int off; int bpw; int words; int mode; int badd; int bmul; int beats;
    logic [31:0] e0; logic [31:0] e1; logic [31:0] e2; logic [31:0] e3;
  } vec_t;

  logic [7:0]  sb [64];
  logic [31:0] tab_exp [4];
  bit          use_tab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input int bpw);
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
`ifndef DLSC_DATA_UNPACKER_ZERO_EN
    for (int b = 0; b < 4; b++) if (b > bpw) m[8*b +: 8] = 8'h00;
`endif
    return m;
  endfunction

  function automatic logic [31:0] beat_of(input int bi);
    int base;
    base = (4*bi) % 60;
    return {sb[base+3], sb[base+2], sb[base+1], sb[base]};
  endfunction

  // Runs one command. mode: 0 full rate, 1 out_ready toggling + random in_valid, 2 fully random.
  task automatic run_cmd(input int off, input int bpw, input int words, input int mode,
                         input int exp_beats_in, input int abort_after);
    int n_bytes, exp_beats, bi, ko, cyc, last_cyc, t;
    bit hold;
    logic [31:0] hold_data, exp_w, m;
    n_bytes   = off + words*(bpw+1);
    exp_beats = (exp_beats_in > 0) ? exp_beats_in : (n_bytes + 3) / 4;
    m = lane_mask(bpw);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_offset = off[1:0]; cmd_bpw = bpw[1:0]; cmd_words = words[WLEN-1:0];
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    bi = 0; ko = 0; cyc = 0; last_cyc = 0; hold = 1'b0; hold_data = '0;
    while (ko < words && cyc < 2000) begin
      @(negedge clk);
      in_valid  = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom % 2);
      in_data   = beat_of(bi);
      #1;
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, hold_data);
      end
      if (cmd_done) check("early_done", 32'(cmd_done), 32'd0);
      if (in_valid && in_ready) begin
        if (bi >= exp_beats) check("extra_beat", bi, exp_beats - 1);
        bi++;
      end
      if (out_valid && out_ready) begin
        exp_w = '0;
        for (int b = 0; b <= bpw; b++) exp_w[8*b +: 8] = sb[off + ko*(bpw+1) + b];
        if (use_tab && ko < 4) exp_w = tab_exp[ko];
        check("out_data", out_data & m, exp_w & m);
        check("out_last", 32'(out_last), 32'(ko == words-1));
        if (mode == 0 && ko > 0) check("throughput_gap", cyc - last_cyc, 1);
        last_cyc = cyc;
        ko++;
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      cyc++;
      if (abort_after > 0 && ko == abort_after) break;
    end
    if (cyc >= 2000) check("run_timeout", ko, words);
    if (abort_after > 0) begin
      rst = 1'b1;
      @(negedge clk); #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      check("abort_cmd_done", 32'(cmd_done), 32'd0);
      rst = 1'b0;
      @(negedge clk); #1;
      check("abort_no_done", 32'(cmd_done), 32'd0);
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); #1;
      check("cmd_done_pulse", 32'(cmd_done), 32'd1);
      check("cmd_ready_after", 32'(cmd_ready), 32'd1);
      check("idle_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); #1;
      check("cmd_done_single", 32'(cmd_done), 32'd0);
      check("beats_consumed", bi, exp_beats);
      in_valid = 1'b0;
    end
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{off:0, bpw:3, words:4, mode:0, badd:8'h00, bmul:1, beats:4,
                e0:32'h03020100, e1:32'h07060504, e2:32'h0B0A0908, e3:32'h0F0E0D0C};
    vecs[1] = '{off:1, bpw:0, words:3, mode:0, badd:8'h11, bmul:8'h11, beats:1,
                e0:32'h00000022, e1:32'h00000033, e2:32'h00000044, e3:32'h0};
    vecs[2] = '{off:3, bpw:1, words:3, mode:0, badd:8'h00, bmul:1, beats:3,
                e0:32'h00000403, e1:32'h00000605, e2:32'h00000807, e3:32'h0};
    vecs[3] = '{off:2, bpw:3, words:2, mode:1, badd:8'h00, bmul:1, beats:3,
                e0:32'h05040302, e1:32'h09080706, e2:32'h0, e3:32'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_offset = '0; cmd_bpw = '0; cmd_words = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; use_tab = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cmd_done", 32'(cmd_done), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 64; i++) sb[i] = 8'(vecs[v].badd + vecs[v].bmul * i);
      tab_exp[0] = vecs[v].e0; tab_exp[1] = vecs[v].e1;
      tab_exp[2] = vecs[v].e2; tab_exp[3] = vecs[v].e3;
      use_tab = 1'b1;
      run_cmd(vecs[v].off, vecs[v].bpw, vecs[v].words, vecs[v].mode, vecs[v].beats, 0);
      use_tab = 1'b0;
    end

    // reset in the middle of a 10-word command, then a clean command
    for (int i = 0; i < 64; i++) sb[i] = 8'(i);
    run_cmd(1, 2, 10, 0, 0, 2);
    for (int i = 0; i < 64; i++) sb[i] = 8'($urandom);
    run_cmd(2, 1, 5, 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 64; i++) sb[i] = 8'($urandom);
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 12)), int'($urandom_range(0, 2)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
